mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between the instruction-fetch stage (read-only) and the data-memory stage (read/write) of the 16-bit five-stage pipeline.
- Serializes requests and runs a fixed-latency memory access per grant.
- Returns one valid pulse to the owning requester.
- While a requester's transaction is pending, the pipeline controller uses the `*_valid` and `busy` outputs to stall the corresponding stage.

Parameters:
- MEM_LAT, 4, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..15.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- if_req  input  1  fetch read request; level, held until if_valid
- if_addr  input  16  fetch address; stable while if_req high
- if_rdata  output  16  fetch read data; valid only with if_valid
- if_valid  output  1  one-cycle completion pulse for fetch
- dm_req  input  1  data-stage request; level, held until dm_valid
- dm_wr  input  1  1 = write, 0 = read; stable while dm_req high
- dm_addr  input  16  data address
- dm_wdata  input  16  write data
- dm_rdata  output  16  data read data; valid only with dm_valid
- dm_valid  output  1  one-cycle completion pulse for data stage
- mem_en  output  1  memory access strobe, one cycle per transaction
- mem_wr  output  1  memory write enable, qualified by mem_en
- mem_addr  output  16  memory address
- mem_wdata  output  16  memory write data
- mem_rdata  input  16  memory read data, valid MEM_LAT cycles after mem_en
- busy  output  1  high in every state except IDLE

Clock, reset and state registers:
- One clock: clk. Reset is asynchronous and active-low: rst_n.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- Registers: owner (0 = fetch, 1 = data), captured address, wr, wdata, and a countdown counter of width $clog2(MEM_LAT+1).

State transitions:
- IDLE: at a rising edge with any req high, capture the winner's address/wr/wdata and set owner → ISSUE. With no req, stay in IDLE.
- Arbitration is fixed priority: dm wins over if (the data stage holds the older instruction).
- ISSUE: lasts exactly 1 cycle.
  - mem_en=1; mem_wr=captured wr (0 for fetch); mem_addr/mem_wdata = captured values.
  - Load counter with MEM_LAT-1.
  - Next state: WAIT if MEM_LAT>1, else DONE.
- WAIT: decrement counter each cycle; when counter==1 → DONE. WAIT therefore spans MEM_LAT-1 cycles.
- DONE: lasts exactly 1 cycle. The owner's valid=1 and its rdata=mem_rdata (16'h0000 for writes) → IDLE.
  - req inputs are ignored in DONE.
  - req sampled in the following IDLE cycle is treated as a new request.

Output rules:
- Latency: req sampled at edge E → mem_en high in cycle E+1 → valid in cycle E+MEM_LAT+1. Back-to-back throughput is one transaction per MEM_LAT+2 cycles.
- mem_en, mem_wr, mem_addr, mem_wdata are registered; all are 0 outside ISSUE.
- if_rdata/dm_rdata are 16'h0000 whenever the corresponding valid is low.
- The non-owner's valid stays 0 for the whole transaction.
- A request arriving mid-transaction waits; it is arbitrated in the next IDLE cycle.
- Requester changing addr/wr/wdata while pending: ignored, because values are captured in IDLE.
- Requester dropping req while pending: the transaction still completes and the valid pulse is still emitted.

Reset:
- rst_n low at any time → immediately IDLE.
- All outputs 0, owner=0, counter=0, and the round-robin pointer (if present) = 0.
- An in-flight transaction is abandoned and no valid is produced for it.
- A req still high after reset release is serviced as a new request.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: adds a last_owner register, reset 0.
  - On a tie in IDLE, grant the requester that did not win last.
  - On no tie, grant the sole requester.
  - last_owner updates on every grant.
- Undefined: fixed dm-over-if priority; the last_owner register is absent.

Test Plan (MEM_LAT=4):
- Reset: assert rst_n=0 with both reqs high → all outputs 0 and busy=0; release → dm serviced first.
- Fetch read alone:
  - Stimulus: if_addr=0x0010; memory model returns 0xC123.
  - Response: mem_en for exactly 1 cycle at E+1 with mem_addr=0x0010, mem_wr=0.
  - Response: if_valid single pulse at E+5 with if_rdata=0xC123; dm_valid stays 0.
- Simultaneous requests: dm write 0x8000/0xBEEF and if read 0x0020, both raised at the same edge.
  - Write issues first (mem_wr=1, mem_wdata=0xBEEF), dm_valid at E+5 with dm_rdata=0x0000.
  - Fetch issue at E+7 with mem_addr=0x0020; if_valid at E+11.
- Back-to-back dm reads to 0x0100 then 0x0102, second presented the cycle after dm_valid → mem_en pulses exactly 6 cycles apart; two valid pulses with the correct data.
- Reset mid-WAIT: drop rst_n for 1 cycle during WAIT with if_req held.
  - No if_valid for the abandoned access.
  - New mem_en 1 cycle after the first post-release edge; if_valid at release+5.
- Both reqs held high for 4 transactions:
  - Without ARB_RR_EN: grant order dm, dm, dm, dm.
  - With ARB_RR_EN: grant order dm, if, dm, if.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch stage
// (read-only) and the data stage (read/write). One request is granted at a
// time; each grant issues a single mem_en strobe, waits MEM_LAT cycles and
// returns one valid pulse to its owner.
// Optional feature macro: ARB_RR_EN (tie-break by alternating owners instead
// of fixed data-over-fetch priority).
module mem_port_arbiter #(
  parameter int MEM_LAT = 4  // mem_en cycle to mem_rdata valid, 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [15:0] if_addr_i,
  output logic [15:0] if_rdata_o,
  output logic        if_valid_o,
  input  logic        dm_req_i,
  input  logic        dm_wr_i,
  input  logic [15:0] dm_addr_i,
  input  logic [15:0] dm_wdata_i,
  output logic [15:0] dm_rdata_o,
  output logic        dm_valid_o,
  output logic        mem_en_o,
  output logic        mem_wr_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic [15:0] mem_rdata_i,
  output logic        busy_o
);

  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;      // 0 = fetch, 1 = data
  logic            wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_wr_q, mem_wr_d;
  logic [15:0]     mem_addr_q, mem_addr_d;
  logic [15:0]     mem_wdata_q, mem_wdata_d;
  logic            grant_dm;              // winner of arbitration when in IDLE

`ifdef ARB_RR_EN
  logic            last_owner_q, last_owner_d;

  // Tie-break toward the requester that did not win last time
  always_comb begin
    grant_dm = dm_req_i;
    if (dm_req_i && if_req_i) grant_dm = ~last_owner_q;
  end

  // Remember the owner of every grant
  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == IDLE && (dm_req_i || if_req_i)) last_owner_d = grant_dm;
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_owner_q <= 1'b0;
    else        last_owner_q <= last_owner_d;
  end
`else
  // Fixed priority: the data stage holds the older instruction
  always_comb grant_dm = dm_req_i;
`endif

  // Next-state and issue logic; request fields are captured only in IDLE so
  // a requester changing them while pending has no effect
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = 16'h0000;
    mem_wdata_d = 16'h0000;
    case (state_q)
      IDLE: begin
        if (dm_req_i || if_req_i) begin
          owner_d     = grant_dm;
          wr_d        = grant_dm & dm_wr_i;
          mem_en_d    = 1'b1;
          mem_wr_d    = grant_dm & dm_wr_i;
          mem_addr_d  = grant_dm ? dm_addr_i : if_addr_i;
          mem_wdata_d = (grant_dm && dm_wr_i) ? dm_wdata_i : 16'h0000;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CW'(MEM_LAT - 1);
        state_d = (MEM_LAT > 1) ? WAIT : DONE;
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = DONE;
      end
      DONE: state_d = IDLE;  // requests are ignored here
      default: state_d = IDLE;
    endcase
  end

  // State and captured-request registers; reset abandons any access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Completion pulses and read data steering; data is zero unless valid
  always_comb begin
    if_valid_o  = (state_q == DONE) && !owner_q;
    dm_valid_o  = (state_q == DONE) && owner_q;
    if_rdata_o  = if_valid_o ? mem_rdata_i : 16'h0000;
    dm_rdata_o  = (dm_valid_o && !wr_q) ? mem_rdata_i : 16'h0000;
    busy_o      = (state_q != IDLE);
    mem_en_o    = mem_en_q;
    mem_wr_o    = mem_wr_q;
    mem_addr_o  = mem_addr_q;
    mem_wdata_o = mem_wdata_q;
  end

endmodule
